hilo_ctrl: RTL
==============

# hilo_ctrl

Pipeline-side front end of the multiply/divide unit: owns the architectural HI/LO registers. Accepts decoded MULT/MULTU/DIV/DIVU/MUL/MTHI/MTLO/MFHI/MFLO from the execute stage, issues start pulses to the unit, and tracks the unit's busy flag. Commits results into HI/LO, returns MUL/MF* data, and stalls the pipeline on HI/LO hazards. Sits between the execute stage and the mul/div unit; the unit receives the same clock and reset.

## Interface
- No parameters.
- Clk  in  1  clock, rising edge
- Clr  in  1  reset, asynchronous, active-high
- op_valid  in  1  execute stage presents an op this cycle
- op_code  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MUL, 6 MTHI, 7 MTLO, 8 MFHI, 9 MFLO, 10–15 NOP
- op_a, op_b  in  32  rs/rt operands
- intreq  in  1  interrupt taken this cycle; the presented op is cancelled
- stall  out  1  hold execute stage
- rd_data  out  32  MUL/MFHI/MFLO result
- rd_valid  out  1  rd_data valid this cycle
- xalu_start  out  1  one-cycle start pulse to the unit
- xalu_sign  out  1  1 for MULT/DIV/MUL
- xalu_is_div  out  1  1 for DIV/DIVU
- xalu_a, xalu_b  out  32  operands, equal to op_a/op_b
- xalu_busy  in  1  unit busy
- xalu_hi, xalu_lo  in  32  unit result
- hi, lo  out  32  architectural HI/LO

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - ISSUE: 1 cycle; xalu_busy ignored.
  - WAIT: remains while xalu_busy=1. A WAIT cycle with xalu_busy=0 is the done cycle; the next state is IDLE.
- Issue: in IDLE, op_valid, !intreq, op is MULT/MULTU/DIV/DIVU/MUL -> xalu_start=1 in that cycle. The controller latches pend_mul = (op==MUL) and moves to ISSUE.
  - MULT/MULTU/DIV/DIVU: stall=0 in the issue cycle.
  - MUL: stall=1 from the issue cycle until the done cycle. The held MUL is never re-issued.
- Done cycle, pend_mul=0: hi<=xalu_hi, lo<=xalu_lo.
- Done cycle, pend_mul=1: rd_data=xalu_lo, rd_valid=1, stall=0. HI/LO are not modified.
- IDLE, no in-flight op:
  - MTHI/MTLO: write hi/lo from op_a at the clock edge.
  - MFHI/MFLO: rd_data=hi/lo combinationally, rd_valid=1, no stall.
- Hazards, non-IDLE states:
  - Any MT*/MF*/mul-div op presented -> stall=1, except the pending MUL in its done cycle.
  - A new mul/div op in the done cycle stalls one cycle. There is no back-to-back issue.
- intreq=1: the op is not performed. No start, no HI/LO write, rd_valid=0, stall=0 (the pending MUL still stalls). An in-flight operation is never cancelled.
- Divide by zero: HI/LO take whatever the unit returns. No trap.
- Reset values: state IDLE, hi=lo=0, pend_mul=0, stall=0, rd_valid=0, xalu_start=0. Reset mid-operation abandons the operation.
- NOP or op_valid=0: no effect. stall=0 except for a pending MUL.

## Timing
- Start at cycle T. ISSUE at T+1. First busy check at T+2.
- Minimum: commit at the end of T+2; the new HI/LO are visible at T+3.
- For unit latency N≥2 (busy high T+1..T+N-1): done cycle = max(T+2, T+N).
- MUL stall length = done cycle − T.
- MT* write is visible to an MF* in the next cycle.
- stall, rd_data and rd_valid are combinational from state, inputs, and registers.

## Configuration
- HILO_BYPASS_EN defined: an MFHI/MFLO in the done cycle (pend_mul=0) returns xalu_hi/xalu_lo with rd_valid=1 and no stall.
- HILO_BYPASS_EN undefined: that MF* stalls one cycle and reads the updated registers in IDLE.

## Structure
- Package hilo_pkg: op_code localparams (HILO_OP_*) and the state encoding (HILO_IDLE, HILO_ISSUE, HILO_WAIT).
- No sub-module. One module: FSM, HI/LO registers, output decode.

## Test plan
- Reset: assert Clr mid-WAIT -> hi=lo=0, state IDLE, stall=0. MFHI next cycle -> rd_data=0.
- MULT 0xFFFFFFFF×2, unit latency 5 (busy T+1..T+4):
  - xalu_start=1, xalu_sign=1 at T.
  - commit at T+5, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MFLO at T+3 stalls through T+5 (bypass off) or through T+4 (bypass on, returns 0xFFFFFFFE at T+5).
- MUL 7×6, latency 3: stall T..T+2. At T+3, rd_valid=1, rd_data=42. hi/lo unchanged. Exactly one xalu_start.
- DIVU 100/7: xalu_is_div=1, xalu_sign=0 -> hi=2, lo=14. A DIV presented in the done cycle stalls one cycle, then issues.
- MTHI 0x1234 then MFHI next cycle -> 0x1234, no stall. MTLO during WAIT -> stall until IDLE, then written.
- intreq with MULT in IDLE -> no xalu_start, hi/lo unchanged. intreq during WAIT -> in-flight DIV still commits.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO controller: op codes and FSM state encoding.
package hilo_pkg;

    localparam int unsigned HILO_DW = 32;
    localparam int unsigned HILO_OPW = 4;

    localparam logic [HILO_OPW-1:0] HILO_OP_NOP   = 4'd0;
    localparam logic [HILO_OPW-1:0] HILO_OP_MULT  = 4'd1;
    localparam logic [HILO_OPW-1:0] HILO_OP_MULTU = 4'd2;
    localparam logic [HILO_OPW-1:0] HILO_OP_DIV   = 4'd3;
    localparam logic [HILO_OPW-1:0] HILO_OP_DIVU  = 4'd4;
    localparam logic [HILO_OPW-1:0] HILO_OP_MUL   = 4'd5;
    localparam logic [HILO_OPW-1:0] HILO_OP_MTHI  = 4'd6;
    localparam logic [HILO_OPW-1:0] HILO_OP_MTLO  = 4'd7;
    localparam logic [HILO_OPW-1:0] HILO_OP_MFHI  = 4'd8;
    localparam logic [HILO_OPW-1:0] HILO_OP_MFLO  = 4'd9;

    typedef enum logic [1:0] {
        HILO_IDLE  = 2'd0,
        HILO_ISSUE = 2'd1,
        HILO_WAIT  = 2'd2
    } hilo_state_t;

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO owner and issue/hazard front end of the multiply/divide unit.
// Optional HILO_BYPASS_EN: MFHI/MFLO in the commit cycle forwards the unit result.
module hilo_ctrl
    import hilo_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Clr,
    input  logic                    op_valid,
    input  logic [HILO_OPW-1:0]     op_code,
    input  logic [HILO_DW-1:0]      op_a,
    input  logic [HILO_DW-1:0]      op_b,
    input  logic                    intreq,
    output logic                    stall,
    output logic [HILO_DW-1:0]      rd_data,
    output logic                    rd_valid,
    output logic                    xalu_start,
    output logic                    xalu_sign,
    output logic                    xalu_is_div,
    output logic [HILO_DW-1:0]      xalu_a,
    output logic [HILO_DW-1:0]      xalu_b,
    input  logic                    xalu_busy,
    input  logic [HILO_DW-1:0]      xalu_hi,
    input  logic [HILO_DW-1:0]      xalu_lo,
    output logic [HILO_DW-1:0]      hi,
    output logic [HILO_DW-1:0]      lo
);

    hilo_state_t        state, state_next;
    logic               pend_mul, pend_mul_next;
    logic               hi_we, lo_we;
    logic [HILO_DW-1:0] hi_d, lo_d;

    logic op_act, is_muldiv, is_mt, is_mf, is_hilo_op;

    // Op classification; an interrupted op is treated as absent.
    assign op_act     = op_valid && !intreq;
    assign is_muldiv  = (op_code >= HILO_OP_MULT) && (op_code <= HILO_OP_MUL);
    assign is_mt      = (op_code == HILO_OP_MTHI) || (op_code == HILO_OP_MTLO);
    assign is_mf      = (op_code == HILO_OP_MFHI) || (op_code == HILO_OP_MFLO);
    assign is_hilo_op = op_act && (is_muldiv || is_mt || is_mf);

    assign xalu_sign   = (op_code == HILO_OP_MULT) || (op_code == HILO_OP_DIV) ||
                         (op_code == HILO_OP_MUL);
    assign xalu_is_div = (op_code == HILO_OP_DIV) || (op_code == HILO_OP_DIVU);
    assign xalu_a      = op_a;
    assign xalu_b      = op_b;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state    <= HILO_IDLE;
            pend_mul <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state    <= state_next;
            pend_mul <= pend_mul_next;
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

    always_comb begin
        state_next    = state;
        pend_mul_next = pend_mul;
        stall         = 1'b0;
        rd_data       = '0;
        rd_valid      = 1'b0;
        xalu_start    = 1'b0;
        hi_we         = 1'b0;
        lo_we         = 1'b0;
        hi_d          = op_a;
        lo_d          = op_a;

        case (state)
            HILO_IDLE: begin
                if (op_act && is_muldiv) begin
                    xalu_start    = 1'b1;
                    pend_mul_next = (op_code == HILO_OP_MUL);
                    stall         = (op_code == HILO_OP_MUL);
                    state_next    = HILO_ISSUE;
                end else if (op_act) begin
                    case (op_code)
                        HILO_OP_MTHI: hi_we = 1'b1;
                        HILO_OP_MTLO: lo_we = 1'b1;
                        HILO_OP_MFHI: begin rd_data = hi; rd_valid = 1'b1; end
                        HILO_OP_MFLO: begin rd_data = lo; rd_valid = 1'b1; end
                        default: ;
                    endcase
                end
            end

            HILO_ISSUE: begin
                state_next = HILO_WAIT;
                stall      = pend_mul || is_hilo_op;
            end

            HILO_WAIT: begin
                if (xalu_busy) begin
                    stall = pend_mul || is_hilo_op;
                end else begin
                    state_next    = HILO_IDLE;
                    pend_mul_next = 1'b0;
                    if (pend_mul) begin
                        // The held MUL completes here and releases the pipeline.
                        rd_data  = xalu_lo;
                        rd_valid = !intreq;
                    end else begin
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        hi_d  = xalu_hi;
                        lo_d  = xalu_lo;
`ifdef HILO_BYPASS_EN
                        if (op_act && is_mf) begin
                            rd_data  = (op_code == HILO_OP_MFHI) ? xalu_hi : xalu_lo;
                            rd_valid = 1'b1;
                        end else begin
                            stall = is_hilo_op;
                        end
`else
                        stall = is_hilo_op;
`endif
                    end
                end
            end

            default: state_next = HILO_IDLE;
        endcase
    end

endmodule
